util_spi_shifter: RTL and testbench
===================================

UTIL_SPI_SHIFTER -- requirements
Module: util_spi_shifter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the frame length in bits (legal range 2..32).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1; 1 means MSB is sent and received first, 0 means LSB first.
REQ-003 The block SHALL have port clk, input, width 1: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, width 1: the reset, asynchronous and active-high.
REQ-005 The block SHALL have port tx_data, input, width DATA_WIDTH: the parallel word to transmit.
REQ-006 The block SHALL have port tx_valid, input, width 1: tx_data is offered.
REQ-007 The block SHALL have port tx_ready, output, width 1: the block accepts a word this cycle.
REQ-008 The block SHALL have port shift_en, input, width 1: one-cycle pulse from the clock generator to advance sdo.
REQ-009 The block SHALL have port latch_en, input, width 1: one-cycle pulse from the clock generator to sample sdi.
REQ-010 The block SHALL have port sdi, input, width 1: serial data in.
REQ-011 The block SHALL have port sdo, output, width 1: serial data out.
REQ-012 The block SHALL have port clk_en, output, width 1: drives the clock generator enable.
REQ-013 The block SHALL have port rx_data, output, width DATA_WIDTH: the last received word.
REQ-014 The block SHALL have port rx_valid, output, width 1: one-cycle pulse when rx_data updates.
REQ-015 The block SHALL have port busy, output, width 1: high while a frame is in progress.

Function
REQ-016 The state machine SHALL have three states: IDLE, SHIFT and DONE.
REQ-017 In IDLE, tx_ready SHALL be 1; in all other states tx_ready SHALL be 0.
REQ-018 When tx_valid and tx_ready are both high at edge N, the block SHALL load tx_data into the tx shift register, clear the bit counter and the first-latch flag, and enter SHIFT; clk_en and busy SHALL be 1 from edge N onward.
REQ-019 sdo SHALL always equal the tx shift register MSB when MSB_FIRST=1, or its LSB when MSB_FIRST=0, so the first bit is valid before the first clock edge.
REQ-020 In SHIFT, latch_en SHALL shift sdi into the rx shift register (toward the MSB when MSB_FIRST=1, toward the LSB otherwise), increment the bit counter and set the first-latch flag.
REQ-021 In SHIFT, shift_en SHALL shift the tx register by one position (shifting in zeros) only if the first-latch flag is set or latch_en is high in the same cycle; a leading shift_en (the CPHA=1 case) SHALL be ignored.
REQ-022 When shift_en and latch_en occur in the same cycle, the block SHALL perform the sample, then the shift.
REQ-023 On the latch_en that makes the bit count equal DATA_WIDTH, the block SHALL drop clk_en on that edge and enter DONE.
REQ-024 Any further shift_en or latch_en pulses received while not in SHIFT SHALL be ignored.
REQ-025 In DONE, the block SHALL copy the rx register to rx_data, pulse rx_valid for exactly one cycle, and return to IDLE on the next edge.
REQ-026 busy SHALL clear when the block enters IDLE.
REQ-027 A back-to-back frame SHALL be accepted at the earliest two cycles after the final latch_en.
REQ-028 The bit counter SHALL be $clog2(DATA_WIDTH+1) bits wide and SHALL never wrap within a frame.
REQ-029 tx_valid SHALL be ignored while busy, and the offered word SHALL NOT be lost; it is held by the source until tx_ready.

Reset
REQ-030 When rst is asserted, asynchronously: the state SHALL be IDLE; tx_ready SHALL be 1; clk_en, busy, rx_valid and sdo SHALL be 0; rx_data, the shift registers and the counter SHALL be 0.
REQ-031 When rst asserts mid-frame, the block SHALL abort the frame with no rx_valid pulse.
REQ-032 The first handshake SHALL be accepted on the first edge after rst deasserts.

Configuration
REQ-033 When UTIL_SPI_SHIFTER_LOOPBACK_EN is defined, the internal sample input SHALL be sdo instead of the sdi port; sdi SHALL be unused and all other behaviour SHALL be unchanged.
REQ-034 When UTIL_SPI_SHIFTER_LOOPBACK_EN is not defined, the block SHALL sample the sdi port.

Structure
REQ-035 The state encoding constants (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) SHALL live in the shared package util_spi_shifter_pkg.
REQ-036 One sub-module, util_shift_reg, SHALL be instantiated twice (tx and rx); it provides a parameterized width, load, shift enable and shift direction.

Verification
REQ-037 DATA_WIDTH=8, MSB_FIRST=1, tx_data=0xA5, sdi looped to sdo, 8 latch_en each followed by shift_en: the sdo sequence SHALL be 1,0,1,0,0,1,0,1, followed by rx_data=0xA5 with one rx_valid pulse.
REQ-038 MSB_FIRST=0, tx_data=0x01, sdi held at 1: sdo SHALL be 1 then 0 for 7 bits, and rx_data SHALL be 0xFF.
REQ-039 With the CPHA=1 pattern (shift_en leading each latch_en), tx_data=0x3C: the leading shift_en SHALL be ignored and rx_data SHALL be 0x3C in loopback.
REQ-040 With shift_en and latch_en pulsed in the same cycle for all 8 bits, tx_data=0x96: the frame SHALL complete in 8 pulses with rx_data=0x96.
REQ-041 With rst asserted after 3 latch_en: there SHALL be no rx_valid, all outputs SHALL be at reset values, and the next frame with tx_data=0x5A SHALL complete correctly.
REQ-042 With tx_valid held high continuously: rx_valid SHALL pulse once per frame, and tx_ready SHALL go high exactly 2 cycles after each final latch_en.

Source files
------------

// File: rtl/util_spi_shifter_pkg.sv
// Purpose : shared definitions for the SPI shift engine (FSM state encoding).
// Latency : n/a (types only).
// Backpressure: n/a.
package util_spi_shifter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/util_shift_reg.sv
// Purpose : generic parallel-load shift register, direction chosen at elaboration.
// Latency : load/shift take effect on the next rising edge.
// Backpressure: none; load has priority over shift.
// Ports   : clk, rst (async active-high), load/load_data, shift/shift_in, q.
module util_shift_reg
    import util_spi_shifter_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit SHIFT_LEFT = 1'b1   // 1: shift toward MSB, new bit enters at LSB
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift,
    input  logic             shift_in,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_data;
        end else if (shift) begin
            if (SHIFT_LEFT) begin
                q <= {q[WIDTH-2:0], shift_in};
            end else begin
                q <= {shift_in, q[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/util_spi_shifter.sv
// Purpose : SPI frame shifter driven by external shift/latch strobes; one frame per tx handshake.
// Latency : rx_valid pulses the cycle after the final latch_en; tx_ready returns one cycle later.
// Backpressure: tx_ready low while busy; the source must hold tx_data/tx_valid until accepted.
// Ports   : clk, rst, tx_data/tx_valid/tx_ready, shift_en, latch_en, sdi, sdo, clk_en,
//           rx_data/rx_valid, busy.
// Config  : define UTIL_SPI_SHIFTER_LOOPBACK_EN to sample sdo internally instead of sdi.
module util_spi_shifter
    import util_spi_shifter_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MSB_FIRST  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic                  shift_en,
    input  logic                  latch_en,
    input  logic                  sdi,
    output logic                  sdo,
    output logic                  clk_en,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    state_t                  state;
    state_t                  state_nxt;
    logic [CNT_W-1:0]        bit_cnt;
    logic                    first_latched;
    logic [DATA_WIDTH-1:0]   tx_q;
    logic [DATA_WIDTH-1:0]   rx_q;
    logic [DATA_WIDTH-1:0]   rx_hold;
    logic                    sample;
    logic                    accept;
    logic                    do_latch;
    logic                    do_shift;
    logic                    last_latch;

    assign accept     = (state == IDLE) && tx_valid;
    assign do_latch   = (state == SHIFT) && latch_en;
    // A shift before any sample is the CPHA=1 leading edge: the first bit is
    // already on sdo, so it must not be shifted away.
    assign do_shift   = (state == SHIFT) && shift_en && (first_latched || latch_en);
    assign last_latch = do_latch && (bit_cnt == CNT_W'(DATA_WIDTH - 1));

    assign sdo = (MSB_FIRST != 0) ? tx_q[DATA_WIDTH-1] : tx_q[0];

`ifdef UTIL_SPI_SHIFTER_LOOPBACK_EN
    assign sample = sdo;
`else
    assign sample = sdi;
`endif

    // Both registers update on the same edge, so a coincident latch/shift
    // samples the old sdo before the tx register moves on.
    util_shift_reg #(
        .WIDTH      (DATA_WIDTH),
        .SHIFT_LEFT (MSB_FIRST != 0)
    ) u_tx (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .load_data (tx_data),
        .shift     (do_shift),
        .shift_in  (1'b0),
        .q         (tx_q)
    );

    util_shift_reg #(
        .WIDTH      (DATA_WIDTH),
        .SHIFT_LEFT (MSB_FIRST != 0)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .load      (1'b0),
        .load_data ('0),
        .shift     (do_latch),
        .shift_in  (sample),
        .q         (rx_q)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (tx_valid)   state_nxt = SHIFT;
            SHIFT:   if (last_latch) state_nxt = DONE;
            DONE:                    state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        tx_ready = (state == IDLE);
        busy     = (state != IDLE);
        clk_en   = (state == SHIFT);
        rx_valid = (state == DONE);
    end

    // Bit counter, first-sample flag and the held copy of the last word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt       <= '0;
            first_latched <= 1'b0;
            rx_hold       <= '0;
        end else begin
            if (accept) begin
                bit_cnt       <= '0;
                first_latched <= 1'b0;
            end else if (do_latch) begin
                bit_cnt       <= bit_cnt + 1'b1;
                first_latched <= 1'b1;
            end
            if (state == DONE) begin
                rx_hold <= rx_q;
            end
        end
    end

    // During DONE the shift register already holds the full word; afterwards
    // the held copy keeps it stable while the next frame shifts in.
    assign rx_data = (state == DONE) ? rx_q : rx_hold;

endmodule

// File: tb/tb_util_spi_shifter.sv
module tb_util_spi_shifter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       shift_en = 1'b0;
    logic       latch_en = 1'b0;
    logic       loop_mode = 1'b1;
    logic       sdi_const = 1'b0;
    logic       lsb_sel = 1'b0;

    logic       sdi_m, sdo_m, tx_ready_m, clk_en_m, rx_valid_m, busy_m;
    logic [7:0] rx_data_m;
    logic       sdi_l, sdo_l, tx_ready_l, clk_en_l, rx_valid_l, busy_l;
    logic [7:0] rx_data_l;

    int tests = 0;
    int fails = 0;
    int vcnt_m = 0;
    int vcnt_l = 0;

    always #5 clk = ~clk;

    assign sdi_m = loop_mode ? sdo_m : sdi_const;
    assign sdi_l = loop_mode ? sdo_l : sdi_const;

    util_spi_shifter #(.DATA_WIDTH(8), .MSB_FIRST(1)) dut_msb (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready_m),
        .shift_en(shift_en), .latch_en(latch_en), .sdi(sdi_m), .sdo(sdo_m), .clk_en(clk_en_m),
        .rx_data(rx_data_m), .rx_valid(rx_valid_m), .busy(busy_m)
    );

    util_spi_shifter #(.DATA_WIDTH(8), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready_l),
        .shift_en(shift_en), .latch_en(latch_en), .sdi(sdi_l), .sdo(sdo_l), .clk_en(clk_en_l),
        .rx_data(rx_data_l), .rx_valid(rx_valid_l), .busy(busy_l)
    );

    // Selected-DUT views
    logic       s_sdo, s_tx_ready, s_clk_en, s_rx_valid, s_busy;
    logic [7:0] s_rx_data;
    int         s_vcnt;
    assign s_sdo      = lsb_sel ? sdo_l      : sdo_m;
    assign s_tx_ready = lsb_sel ? tx_ready_l : tx_ready_m;
    assign s_clk_en   = lsb_sel ? clk_en_l   : clk_en_m;
    assign s_rx_valid = lsb_sel ? rx_valid_l : rx_valid_m;
    assign s_busy     = lsb_sel ? busy_l     : busy_m;
    assign s_rx_data  = lsb_sel ? rx_data_l  : rx_data_m;
    assign s_vcnt     = lsb_sel ? vcnt_l     : vcnt_m;

    always @(posedge clk) begin
        if (rx_valid_m) vcnt_m <= vcnt_m + 1;
        if (rx_valid_l) vcnt_l <= vcnt_l + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode 0: latch then shift on the next cycle; 1: shift leads each latch (CPHA=1);
    // 2: shift and latch together. Stray strobes are applied during DONE.
    task automatic frame(input logic [7:0] d, input int mode, input bit hold,
                         input logic [7:0] exp_rx, input logic [7:0] exp_seq, input string tag);
        int         v0;
        logic [7:0] seq;
        bit         got;
        seq      = 8'h00;
        tx_data  = d;
        tx_valid = 1'b1;
        got      = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            if (s_tx_ready) got = 1'b1;
            else step();
        end
        check({tag, " ready"}, 32'(got), 32'd1);
        if (!got) begin
            tx_valid = 1'b0;
            return;
        end
        step();
        if (hold) tx_data = ~d;   // must be ignored while busy
        else      tx_valid = 1'b0;
        check({tag, " busy/clk_en"}, {30'd0, s_busy, s_clk_en}, 32'h3);
        v0 = s_vcnt;
        for (int i = 0; i < 8; i++) begin
            if (mode == 1) begin
                shift_en = 1'b1;
                step();
                shift_en = 1'b0;
            end
            seq[7-i] = s_sdo;
            latch_en = 1'b1;
            shift_en = (mode == 2);
            step();
            latch_en = 1'b0;
            shift_en = 1'b0;
            if (i < 7 && mode == 0) begin
                shift_en = 1'b1;
                step();
                shift_en = 1'b0;
            end
        end
        check({tag, " done rx_valid/clk_en/tx_ready"},
              {29'd0, s_rx_valid, s_clk_en, s_tx_ready}, 32'h4);
        check({tag, " rx_data in done"}, 32'(s_rx_data), 32'(exp_rx));
        shift_en = 1'b1;
        latch_en = 1'b1;
        step();
        shift_en = 1'b0;
        latch_en = 1'b0;
        check({tag, " idle tx_ready/busy/rx_valid"},
              {29'd0, s_tx_ready, s_busy, s_rx_valid}, 32'h4);
        check({tag, " rx_data held"}, 32'(s_rx_data), 32'(exp_rx));
        check({tag, " sdo sequence"}, 32'(seq), 32'(exp_seq));
        check({tag, " rx_valid count"}, 32'(s_vcnt - v0), 32'd1);
    endtask

    typedef struct {
        logic [7:0] data;
        int         mode;
        bit         loop;
        bit         sdi_val;
        bit         lsb;
        logic [7:0] exp_rx;
        logic [7:0] exp_seq;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int v_before;

        vecs[0] = '{8'hA5, 0, 1'b1, 1'b0, 1'b0, 8'hA5, 8'hA5};
        vecs[1] = '{8'h01, 0, 1'b0, 1'b1, 1'b1, 8'hFF, 8'h80};
        vecs[2] = '{8'h3C, 1, 1'b1, 1'b0, 1'b0, 8'h3C, 8'h3C};
        vecs[3] = '{8'h96, 2, 1'b1, 1'b0, 1'b0, 8'h96, 8'h96};
        vecs[4] = '{8'h01, 0, 1'b1, 1'b0, 1'b1, 8'h01, 8'h80};
        vecs[5] = '{8'hC3, 2, 1'b0, 1'b0, 1'b0, 8'h00, 8'hC3};
        vecs[6] = '{8'h5A, 1, 1'b0, 1'b1, 1'b1, 8'hFF, 8'h5A};

        // Reset values while rst is held
        #12;
        check("reset msb ctl", {27'd0, tx_ready_m, clk_en_m, busy_m, rx_valid_m, sdo_m}, 32'h10);
        check("reset lsb ctl", {27'd0, tx_ready_l, clk_en_l, busy_l, rx_valid_l, sdo_l}, 32'h10);
        check("reset rx_data", {16'd0, rx_data_m, rx_data_l}, 32'h0);

        // First handshake on the first edge after reset release, then abort
        @(posedge clk);
        #1;
        rst      = 1'b0;
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        check("first accept busy/clk_en", {30'd0, busy_m, clk_en_m}, 32'h3);
        v_before = vcnt_m;
        for (int i = 0; i < 3; i++) begin
            latch_en = 1'b1;
            shift_en = 1'b1;
            step();
        end
        latch_en = 1'b0;
        shift_en = 1'b0;
        check("mid-frame clk_en/sdo", {30'd0, clk_en_m, sdo_m}, 32'h3);
        #3;
        rst = 1'b1;
        #1;
        check("abort async ctl", {27'd0, tx_ready_m, clk_en_m, busy_m, rx_valid_m, sdo_m}, 32'h10);
        step();
        step();
        rst = 1'b0;
        step();
        check("abort no rx_valid", 32'(vcnt_m - v_before), 32'd0);
        check("abort rx_data", 32'(rx_data_m), 32'd0);

        lsb_sel   = 1'b0;
        loop_mode = 1'b1;
        frame(8'h5A, 0, 1'b0, 8'h5A, 8'h5A, "recover");

        for (int n = 0; n < 7; n++) begin
            loop_mode = vecs[n].loop;
            sdi_const = vecs[n].sdi_val;
            lsb_sel   = vecs[n].lsb;
            frame(vecs[n].data, vecs[n].mode, 1'b0, vecs[n].exp_rx, vecs[n].exp_seq,
                  $sformatf("vec%0d", n));
        end

        // tx_valid held high across back-to-back frames
        lsb_sel   = 1'b0;
        loop_mode = 1'b1;
        frame(8'h81, 2, 1'b1, 8'h81, 8'h81, "held0");
        frame(8'h42, 0, 1'b1, 8'h42, 8'h42, "held1");
        tx_valid = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
